grey_frame_writer: RTL
======================

// Module: grey_frame_writer
// PURPOSE
//  Sequences RGB pixels from the capture stream through a greyscale conversion pipeline.
//  Writes the 8-bit grey result into the single-port frame buffer at a raster address.
//  Tracks x/y position, frames pixels between start-of-frame markers and applies backpressure.
//  Sits between the camera capture stage and the frame buffer write port.
// PARAMETERS
//  H_RES   640  active pixels per line
//  V_RES   480  active lines per frame
//  ADDR_W  19   frame buffer address width; must satisfy 2**ADDR_W >= H_RES*V_RES
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, active-high
//  enable      in   1       allow capture of new frames
//  s_valid     in   1       input pixel valid
//  s_ready     out  1       input pixel accepted when s_valid & s_ready
//  s_sof       in   1       qualifies the input pixel as first of frame
//  s_red       in   8       red channel
//  s_green     in   8       green channel
//  s_blue      in   8       blue channel
//  m_we        out  1       frame buffer write request; held until m_ready
//  m_ready     in   1       frame buffer accepts write this cycle
//  m_addr      out  ADDR_W  write address = y*H_RES + x
//  m_data      out  8       grey pixel
//  frame_done  out  1       one-cycle pulse when last pixel write is accepted
//  sync_err    out  1       one-cycle pulse on unexpected s_sof mid-frame
//  busy        out  1       high while state != IDLE or any pipeline stage is valid
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, x=y=0, all pipeline valid bits cleared.
//  Reset mid-frame discards in-flight pixels; no write completes after reset.
//  FSM: IDLE -> RUN when enable & s_valid & s_sof (that pixel is accepted as x=0,y=0).
//  In IDLE: s_ready=1 and pixels without s_sof are accepted and dropped (flush to sync).
//  RUN -> IDLE when the last pixel (H_RES-1,V_RES-1) is accepted at input.
//  Deasserting enable mid-frame has no effect; the frame completes.
//  Pipeline: S1 registers sum = R+G+B (10b).
//  S2 registers grey = (sum*85)[15:8]; max 765*85=65025, so no saturation is needed.
//  Latency: accept at cycle N -> m_we=1 with data at cycle N+2, if there is no stall.
//  Stall: S2 holds while m_we & !m_ready; S1 advances only if S2 is empty or draining.
//  s_ready (RUN) = !S1.valid | S1 advancing. Throughput is 1 pixel/clk with m_ready high.
//  m_addr/m_data are stable while m_we is high and m_ready is low.
//  Address: incremental counter carried with the pixel through the pipeline.
//  x wraps at H_RES-1 to 0 with y+1; after the last pixel x=y=0.
//  s_sof while RUN with (x,y)!=(0,0): sync_err pulse.
//  That pixel restarts the frame at address 0; pixels already in the pipeline still write.
//  frame_done pulses on the m_we & m_ready cycle carrying address H_RES*V_RES-1.
//  It may coincide with acceptance of the next frame's sof pixel.
// STRUCTURE
//  Shared package: H_RES/V_RES defaults, ADDR_W, FSM state encoding.
//  Shared package: grey coefficient constant (85) and shift (8).
//  Sub-module grey_pipe: two-stage sum/scale pipeline with valid/stall.
//  Top level holds the FSM, x/y/address counters and handshake logic.
// TESTING
//  1. H_RES=4,V_RES=2, m_ready=1, 8 pixels R=G=B=255 with sof on first:
//     8 writes, addr 0..7, data 0xFE; frame_done on addr 7 write.
//  2. Pixel R=30,G=60,B=90 -> m_data=(180*85)>>8=59, m_we exactly 2 cycles after accept.
//  3. m_ready low for 5 cycles mid-frame: s_ready falls within 1 cycle.
//     m_addr/m_data held; no pixel lost or duplicated; addresses stay contiguous.
//  4. sof reasserted at pixel x=2,y=0: sync_err pulse, that pixel written to addr 0,
//     and following pixels continue at 1,2...
//  5. Pixels without sof in IDLE dropped (no m_we); enable=0 mid-frame still finishes;
//     after it, next sof is ignored.
//  6. rst asserted with S1,S2 full: m_we=0 immediately, busy=0, next frame starts at addr 0.

Source files
------------

// File: rtl/grey_frame_writer_pkg.sv
// Shared definitions for the greyscale frame writer.
//   - Default frame geometry and frame buffer address width.
//   - FSM state encoding.
//   - Grey conversion constants and the helper that applies them to an R+G+B sum.
package grey_frame_writer_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;

    // grey = (R+G+B) * 85 / 256, which approximates (R+G+B) / 3.
    localparam int GREY_COEF  = 85;
    localparam int GREY_SHIFT = 8;

    // R+G+B of three 8-bit channels needs 10 bits (max 765).
    localparam int SUM_W = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Max product is 765*85 = 65025, so 16 bits hold it without saturation.
    function automatic logic [7:0] grey_of(input logic [SUM_W-1:0] sum);
        logic [15:0] prod;
        prod = 16'(sum) * 16'(GREY_COEF);
        return prod[GREY_SHIFT +: 8];
    endfunction

endpackage

// File: rtl/grey_frame_writer_grey_pipe.sv
// Two-stage greyscale pipeline carrying the write address with each pixel.
//   S1: registers sum = R+G+B and the address.
//   S2: registers grey = (sum*85)>>8 and the address; S2 drives the write port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i          pixel offered to S1 (loaded when in_ready_o is high)
//   in_ready_o          S1 can take a pixel this cycle
//   in_red/green/blue_i colour channels
//   in_addr_i           frame buffer address of the pixel
//   out_valid_o         S2 holds a pixel (write request)
//   out_ready_i         downstream accepts the S2 pixel this cycle
//   out_grey_o          grey value of the S2 pixel
//   out_addr_o          address of the S2 pixel
//   s1_valid_o          S1 occupancy, for the busy indication
// Handshake: a transfer happens on any cycle where valid and ready are both
// high; S2 contents are held unchanged while out_valid_o & !out_ready_i.
module grey_frame_writer_grey_pipe
    import grey_frame_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_red_i,
    input  logic [7:0]        in_green_i,
    input  logic [7:0]        in_blue_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_grey_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              s1_valid_o
);

    logic              s1_valid_q;
    logic [SUM_W-1:0]  s1_sum_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_valid_q;
    logic [7:0]        s2_grey_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              s2_adv;

    // S2 can take new contents when it is empty or its pixel leaves now.
    assign s2_adv     = !s2_valid_q || out_ready_i;
    // S1 can reload when empty or when its pixel moves into S2.
    assign in_ready_o = !s1_valid_q || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_grey_q  <= '0;
            s2_addr_q  <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                s2_grey_q  <= grey_of(s1_sum_q);
                s2_addr_q  <= s1_addr_q;
            end
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
                s1_sum_q   <= SUM_W'(in_red_i) + SUM_W'(in_green_i) + SUM_W'(in_blue_i);
                s1_addr_q  <= in_addr_i;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_grey_o  = s2_grey_q;
    assign out_addr_o  = s2_addr_q;
    assign s1_valid_o  = s1_valid_q;

endmodule

// File: rtl/grey_frame_writer.sv
// Greyscale frame writer: takes RGB pixels from the capture stream, converts
// them to 8-bit grey and writes them into the frame buffer at y*H_RES + x.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   allow a new frame to start on an s_sof pixel
//   s_valid/s_ready          input pixel handshake
//   s_sof                    input pixel is first of frame
//   s_red/s_green/s_blue     colour channels
//   m_we/m_ready             frame buffer write handshake
//   m_addr/m_data            write address and grey data
//   frame_done               pulse when the last pixel's write is accepted
//   sync_err                 pulse when s_sof arrives mid-frame
//   busy                     FSM running or pipeline occupied
//   dbg_state                current FSM state
// Handshake: a transfer happens on any cycle where valid and ready are both
// high; m_we, m_addr and m_data stay unchanged while m_we & !m_ready.
module grey_frame_writer
    import grey_frame_writer_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [7:0]        s_red,
    input  logic [7:0]        s_green,
    input  logic [7:0]        s_blue,
    output logic              m_we,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_data,
    output logic              frame_done,
    output logic              sync_err,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              pipe_in_ready;
    logic              pipe_s1_valid;
    logic              start_req;
    logic              accept;
    logic              take;
    logic              restart;
    logic [X_W-1:0]    px;
    logic [Y_W-1:0]    py;
    logic [ADDR_W-1:0] paddr;
    logic              pix_last;

    // A frame-starting pixel in IDLE must fit into the pipeline, which may
    // still be draining the previous frame; everything else in IDLE is
    // dropped and so can always be accepted.
    assign start_req = enable && s_sof;
    assign s_ready   = (state_q == ST_IDLE && !start_req) ? 1'b1 : pipe_in_ready;
    assign accept    = s_valid && s_ready;
    assign take      = accept && (state_q == ST_RUN || start_req);

    // Pixel position: a frame start (from IDLE or a mid-frame re-sync)
    // places the pixel at (0,0), otherwise it takes the running counters.
    assign restart  = (state_q == ST_IDLE) || s_sof;
    assign px       = restart ? '0 : x_q;
    assign py       = restart ? '0 : y_q;
    assign paddr    = restart ? '0 : addr_q;
    assign pix_last = (px == X_LAST) && (py == Y_LAST);

    assign sync_err = accept && (state_q == ST_RUN) && s_sof &&
                      (x_q != '0 || y_q != '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        if (take) begin
            if (pix_last) begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
            end else begin
                state_d = ST_RUN;
                addr_d  = paddr + ADDR_W'(1);
                if (px == X_LAST) begin
                    x_d = '0;
                    y_d = py + Y_W'(1);
                end else begin
                    x_d = px + X_W'(1);
                    y_d = py;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
        end
    end

    grey_frame_writer_grey_pipe #(
        .ADDR_W (ADDR_W)
    ) u_grey_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (take),
        .in_ready_o  (pipe_in_ready),
        .in_red_i    (s_red),
        .in_green_i  (s_green),
        .in_blue_i   (s_blue),
        .in_addr_i   (paddr),
        .out_valid_o (m_we),
        .out_ready_i (m_ready),
        .out_grey_o  (m_data),
        .out_addr_o  (m_addr),
        .s1_valid_o  (pipe_s1_valid)
    );

    assign frame_done = m_we && m_ready && (m_addr == LAST_ADDR);
    assign busy       = (state_q != ST_IDLE) || pipe_s1_valid || m_we;
    assign dbg_state  = state_q;

endmodule
